mesh_sync_root: RTL
===================

// Module: mesh_sync_root
// PURPOSE
//   Root responder of the mesh fractal synchronisation tree, replacing the fixed single-port echo.
//   Collects barrier requests from N_PORTS subtree roots and checks that all masked participants agree on level.
//   Then, after a programmable latency, wakes every arrived port, with a per-port error flag, and waits for each ack.
//   Adds barrier masks, level-mismatch/double-sync/timeout detection and a barrier counter.
// PARAMETERS
//   N_PORTS    2   number of subtree ports served (>=1)
//   LVL_W      2   width of the level field carried with each request
//   WAKE_LAT   1   cycles from barrier completion to wake_o assertion (>=1)
//   TIMEOUT_W  16  width of the collect-phase timeout counter
// PORTS
//   clk_i           in   1               clock
//   rst_ni          in   1               asynchronous active-low reset
//   barrier_mask_i  in   N_PORTS         ports required to complete a barrier; sampled on IDLE->COLLECT
//   timeout_i       in   TIMEOUT_W       collect timeout in cycles; 0 disables
//   sync_i          in   N_PORTS         one-cycle request pulse per port
//   lvl_i           in   N_PORTS*LVL_W   request level, valid with sync_i[p]
//   ack_i           in   N_PORTS         one-cycle wake acknowledge per port
//   wake_o          out  N_PORTS         wake, held until ack_i[p]
//   error_o         out  N_PORTS         error qualifier, valid while wake_o[p]
//   busy_o          out  1               FSM not in IDLE
//   barrier_cnt_o   out  32              completed barriers (error or not), wraps at 2^32
// BEHAVIOUR
//   Reset: wake_o, error_o, busy_o, barrier_cnt_o = 0; FSM = IDLE; arrived/pending/err regs cleared. Reset mid-barrier drops all state.
//   Regs: arrived[N], err[N], ref_lvl, mask_q, pend[N]+pend_lvl[N], tmo_cnt, lat_cnt.
//   IDLE: first cycle with any sync_i (or any pend) -> COLLECT; mask_q<=barrier_mask_i; ref_lvl<=lvl of lowest-index requester.
//     Requesters (and pend ports) set arrived; pend cleared.
//   COLLECT: each sync_i[p] sets arrived[p]; err[p] set if lvl!=ref_lvl, if p not in mask_q, or if arrived[p] already set (double sync).
//     Level mismatch also sets err of every arrived port.
//     Exit when (arrived & mask_q)==mask_q -> LATENCY; evaluated on registered arrived (request pulse at edge t, LATENCY entered at t+1).
//     tmo_cnt counts cycles in COLLECT; reaching timeout_i!=0 sets err on all arrived ports -> LATENCY.
//   LATENCY: lat_cnt counts WAKE_LAT-1 cycles then -> WAKE. wake_o[p]=arrived[p] rises exactly WAKE_LAT cycles after LATENCY entry.
//     New syncs here and in WAKE go to pend[p]/pend_lvl[p]; a second sync on a pending port is dropped.
//   WAKE: wake_o[p]/error_o[p] held until ack_i[p]; that clears arrived[p], wake_o[p] and err[p] next edge.
//     ack_i on a non-waking port ignored. When arrived==0 -> IDLE, barrier_cnt_o+1.
//   Simultaneous: sync+ack same port in WAKE -> ack completes current, sync pends. Mask changes outside IDLE ignored.
//   Mask of 0: any request completes on arrival (error-flagged as unmasked); a timeout-aborted barrier still counts.
// TESTING
//   mask=2'b11, both sync lvl=1 same cycle t, WAKE_LAT=1 -> wake_o=11 at t+2, error_o=00; acks -> busy_o=0, cnt=1.
//   sync p0 lvl=1 at t, p1 lvl=2 at t+3 -> wake_o=11, error_o=11; acks at different cycles clear wake_o individually.
//   mask=11, timeout_i=8, only p0 syncs -> after 8 COLLECT cycles wake_o=01, error_o=01; cnt increments.
//   Sync p0 during WAKE of previous barrier -> pend; after IDLE, new COLLECT starts with arrived[0]=1 without new pulse.
//   WAKE_LAT=4, double sync p1 in COLLECT -> error_o[1]=1 only; wake 4 cycles after completion.
//   Assert rst_ni low while wake_o=11 -> all outputs 0 immediately; fresh barrier afterwards behaves as case 1.

Source files
------------

// File: rtl/mesh_sync_root.sv
// mesh_sync_root: root responder of the mesh synchronisation tree.
// Collects level-tagged barrier requests from N_PORTS subtree roots, flags
// level mismatches, unmasked and double requests, aborts on timeout, then
// wakes every arrived port after WAKE_LAT cycles and waits for each ack.
module mesh_sync_root #(
  parameter int N_PORTS   = 2,
  parameter int LVL_W     = 2,
  parameter int WAKE_LAT  = 1,
  parameter int TIMEOUT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_PORTS-1:0]       barrier_mask_i,
  input  logic [TIMEOUT_W-1:0]     timeout_i,
  input  logic [N_PORTS-1:0]       sync_i,
  input  logic [N_PORTS*LVL_W-1:0] lvl_i,
  input  logic [N_PORTS-1:0]       ack_i,
  output logic [N_PORTS-1:0]       wake_o,
  output logic [N_PORTS-1:0]       error_o,
  output logic                     busy_o,
  output logic [31:0]              barrier_cnt_o
);

  localparam int LAT_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_LATENCY = 2'd2,
    ST_WAKE    = 2'd3
  } state_t;

  // Level field of port p out of the packed level bus.
  function automatic logic [LVL_W-1:0] lvl_of(input logic [N_PORTS*LVL_W-1:0] v, input int p);
    return v[p*LVL_W +: LVL_W];
  endfunction

  state_t               state_r, state_s;
  logic [N_PORTS-1:0]   arrived_r, arrived_s;
  logic [N_PORTS-1:0]   err_r, err_s;
  logic [LVL_W-1:0]     ref_lvl_r, ref_lvl_s;
  logic [N_PORTS-1:0]   mask_r, mask_s;
  logic [N_PORTS-1:0]   pend_r, pend_s;
  logic [LVL_W-1:0]     pend_lvl_r [N_PORTS];
  logic [LVL_W-1:0]     pend_lvl_s [N_PORTS];
  logic [TIMEOUT_W-1:0] tmo_cnt_r, tmo_cnt_s, tmo_inc_s;
  logic [LAT_W-1:0]     lat_cnt_r, lat_cnt_s;
  logic [N_PORTS-1:0]   wake_r, wake_s;
  logic [N_PORTS-1:0]   error_r, error_s;
  logic                 busy_r, busy_s;
  logic [31:0]          cnt_r, cnt_s;
  logic [N_PORTS-1:0]   req_s, ack_eff_s;
  logic [LVL_W-1:0]     req_lvl_s [N_PORTS];
  logic                 found_s, mism_s;

  // Next-state, barrier bookkeeping and next output values.
  always_comb begin
    state_s    = state_r;
    arrived_s  = arrived_r;
    err_s      = err_r;
    ref_lvl_s  = ref_lvl_r;
    mask_s     = mask_r;
    pend_s     = pend_r;
    pend_lvl_s = pend_lvl_r;
    tmo_cnt_s  = tmo_cnt_r;
    tmo_inc_s  = tmo_cnt_r + TIMEOUT_W'(1);
    lat_cnt_s  = lat_cnt_r;
    wake_s     = '0;
    cnt_s      = cnt_r;
    req_s      = sync_i | pend_r;
    ack_eff_s  = ack_i & wake_r;
    found_s    = 1'b0;
    mism_s     = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      req_lvl_s[p] = pend_r[p] ? pend_lvl_r[p] : lvl_of(lvl_i, p);
    end

    case (state_r)
      ST_IDLE: begin
        if (|req_s) begin
          // Pending ports count as requesters; the lowest-index one sets the level.
          state_s   = ST_COLLECT;
          mask_s    = barrier_mask_i;
          tmo_cnt_s = '0;
          for (int p = 0; p < N_PORTS; p++) begin
            if (req_s[p] && !found_s) begin
              ref_lvl_s = req_lvl_s[p];
              found_s   = 1'b1;
            end else begin
              found_s   = found_s;
            end
          end
          for (int p = 0; p < N_PORTS; p++) begin
            if (req_s[p]) begin
              arrived_s[p] = 1'b1;
              err_s[p]     = !barrier_mask_i[p] || (req_lvl_s[p] != ref_lvl_s) ||
                             (pend_r[p] && sync_i[p]);
              mism_s       = mism_s || (req_lvl_s[p] != ref_lvl_s);
            end else begin
              err_s[p]     = err_r[p];
            end
          end
          if (mism_s) begin
            err_s = err_s | arrived_s;
          end else begin
            err_s = err_s;
          end
          pend_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_COLLECT: begin
        for (int p = 0; p < N_PORTS; p++) begin
          if (sync_i[p]) begin
            arrived_s[p] = 1'b1;
            if ((lvl_of(lvl_i, p) != ref_lvl_r) || !mask_r[p] || arrived_r[p]) begin
              err_s[p] = 1'b1;
            end else begin
              err_s[p] = err_r[p];
            end
            mism_s = mism_s || (lvl_of(lvl_i, p) != ref_lvl_r);
          end else begin
            arrived_s[p] = arrived_r[p];
          end
        end
        if (mism_s) begin
          err_s = err_s | arrived_s;
        end else begin
          err_s = err_s;
        end
        // Completion uses the registered arrival set; it wins over a same-cycle timeout.
        if ((arrived_r & mask_r) == mask_r) begin
          state_s   = ST_LATENCY;
          lat_cnt_s = '0;
        end else if ((timeout_i != '0) && (tmo_inc_s == timeout_i)) begin
          state_s   = ST_LATENCY;
          lat_cnt_s = '0;
          err_s     = err_s | arrived_s;
        end else begin
          tmo_cnt_s = tmo_inc_s;
        end
      end

      ST_LATENCY, ST_WAKE: begin
        // Requests for the next barrier are parked; a second one on a parked port is dropped.
        for (int p = 0; p < N_PORTS; p++) begin
          if (sync_i[p] && !pend_r[p]) begin
            pend_s[p]     = 1'b1;
            pend_lvl_s[p] = lvl_of(lvl_i, p);
          end else begin
            pend_s[p]     = pend_r[p];
          end
        end
        if (state_r == ST_LATENCY) begin
          if (lat_cnt_r == LAT_W'(WAKE_LAT - 1)) begin
            state_s = ST_WAKE;
            wake_s  = arrived_r;
          end else begin
            lat_cnt_s = lat_cnt_r + LAT_W'(1);
          end
        end else begin
          arrived_s = arrived_r & ~ack_eff_s;
          err_s     = err_r & ~ack_eff_s;
          wake_s    = wake_r & ~ack_eff_s;
          if (arrived_r == '0) begin
            state_s = ST_IDLE;
            cnt_s   = cnt_r + 32'd1;
          end else begin
            state_s = ST_WAKE;
          end
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    error_s = err_s & wake_s;
    busy_s  = (state_s != ST_IDLE);
  end

  // State and output registers; reset drops any barrier in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      arrived_r  <= '0;
      err_r      <= '0;
      ref_lvl_r  <= '0;
      mask_r     <= '0;
      pend_r     <= '0;
      pend_lvl_r <= '{default: '0};
      tmo_cnt_r  <= '0;
      lat_cnt_r  <= '0;
      wake_r     <= '0;
      error_r    <= '0;
      busy_r     <= 1'b0;
      cnt_r      <= 32'd0;
    end else begin
      state_r    <= state_s;
      arrived_r  <= arrived_s;
      err_r      <= err_s;
      ref_lvl_r  <= ref_lvl_s;
      mask_r     <= mask_s;
      pend_r     <= pend_s;
      pend_lvl_r <= pend_lvl_s;
      tmo_cnt_r  <= tmo_cnt_s;
      lat_cnt_r  <= lat_cnt_s;
      wake_r     <= wake_s;
      error_r    <= error_s;
      busy_r     <= busy_s;
      cnt_r      <= cnt_s;
    end
  end

  assign wake_o        = wake_r;
  assign error_o       = error_r;
  assign busy_o        = busy_r;
  assign barrier_cnt_o = cnt_r;

endmodule
